// File: rtl/inst_buffer.sv
// Dual-issue instruction FIFO between fetch and decode: up to two pushes and two
// in-order pops per cycle, zero-latency output from registered state, flush empties it.
module inst_buffer #(
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         pause_buffer_i,
  input  logic [225:0] fetch_i,
  input  logic [67:0]  fetch_branch_i,
  input  logic         dec_ready_i,
  output logic [291:0] dec_o,
  output logic [1:0]   dec_valid_o,
  output logic         full_o
);

  // fetch_i slot s: cause[s*42+:42] (cause k at k*7), is_exception[84+s*6+:6],
  // valid[97:96], pc[98+s*32+:32], inst[162+s*32+:32].
  // fetch_branch_i slot s: {is_branch, pre_taken_or_not, pre_branch_addr[31:0]} at s*34.
  // pc_id_t (146b): {pc, inst, is_exception, exception_cause, pre_is_branch,
  // pre_is_branch_taken, pre_branch_addr}; dec_o slot s at s*146.
  localparam int EW = 146;
  localparam int CW = PTR_WIDTH + 1;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PTR_WIDTH-1:0] wr0_idx, wr1_idx, rd1_idx;
  logic [EW-1:0]        entry_in [2];
  logic [1:0]           fetch_valid;
  logic [1:0]           push_num, pop_num;
  logic                 push_en, pop_en;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign entry_in[gi] = {fetch_i[98 + gi*32 +: 32],
                           fetch_i[162 + gi*32 +: 32],
                           fetch_i[84 + gi*6 +: 6],
                           fetch_i[gi*42 +: 42],
                           fetch_branch_i[gi*34 +: 34]};
  end

  assign fetch_valid = fetch_i[97:96];

  assign full_o      = count_q > CW'(DEPTH - 2);
  assign dec_valid_o = flush_i ? 2'b00 : {count_q >= CW'(2), count_q != '0};
  assign rd1_idx     = head_q + PTR_WIDTH'(1);
  assign dec_o       = {mem_q[rd1_idx], mem_q[head_q]};

  // Full is judged on the pre-update count, so a same-cycle pop cannot admit a push.
  assign push_en = !flush_i && !full_o;
  assign pop_en  = dec_ready_i && !pause_buffer_i && !flush_i;

  assign push_num = push_en ? ({1'b0, fetch_valid[0]} + {1'b0, fetch_valid[1]}) : 2'd0;
  assign pop_num  = pop_en ? ({1'b0, dec_valid_o[0]} + {1'b0, dec_valid_o[1]}) : 2'd0;

  // Slot1 lands right after slot0, or at tail itself when slot0 is empty.
  assign wr0_idx = tail_q;
  assign wr1_idx = tail_q + PTR_WIDTH'(fetch_valid[0]);

  always_comb begin
    head_d  = head_q + PTR_WIDTH'(pop_num);
    tail_d  = tail_q + PTR_WIDTH'(push_num);
    count_d = count_q + CW'(push_num) - CW'(pop_num);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_en) begin
      if (fetch_valid[0]) mem_q[wr0_idx] <= entry_in[0];
      if (fetch_valid[1]) mem_q[wr1_idx] <= entry_in[1];
    end
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-issue instruction FIFO between the fetch/icache output and the decoder.
- Each cycle it accepts up to two fetched instructions, each with its exception vector and branch-prediction info.
- Each cycle it presents up to two pc_id_t entries to the decoder in program order.
- It decouples fetch from decode stalls, and a flush empties it completely.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- PTR_WIDTH, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  empty the buffer (branch_flush or exception/ertn redirect).
- pause_buffer_i  in  1  pause_buffer field of pause_t; blocks pops.
- fetch_i  in  226  inst_and_pc_t: per-slot inst/pc, valid[1:0], is_exception, exception_cause.
- fetch_branch_i  in  68  branch_info_t[1:0], slot-aligned with fetch_i.
- dec_ready_i  in  1  decoder takes every valid output entry this cycle.
- dec_o  out  292  pc_id_t[1:0]; slot 0 is the older instruction.
- dec_valid_o  out  2  per-slot output valid.
- full_o  out  1  fewer than 2 free entries; fetch must hold its current fetch_i.

Behaviour:
- Storage is DEPTH entries of pc_id_t.
  - Entry fields are pc, inst, is_exception, exception_cause, pre_is_branch, pre_is_branch_taken, pre_branch_addr.
  - Branch fields come from branch_info_t: is_branch, pre_taken_or_not, pre_branch_addr.
- State: head, tail (PTR_WIDTH bits, wrap mod DEPTH), count (PTR_WIDTH+1 bits, range 0..DEPTH).
- Reset, asynchronous while rst_n=0:
  - head=tail=count=0 and all storage zeroed.
  - dec_valid_o=2'b00, dec_o=0, full_o=0.
- full_o is combinational from the registered count: full_o = (count > DEPTH-2).
- Push happens when !flush_i && !full_o.
  - Valid slots are written in slot order starting at tail: slot0 first if valid[0], then slot1 if valid[1].
  - valid=2'b10 writes slot1 alone into entry tail.
  - push_num is the popcount of valid; tail advances by push_num.
  - While full_o=1 all input is ignored. Fetch holds its data, and nothing is written partially.
- Output has zero read latency from registered state:
  - dec_o[0]=mem[head], dec_o[1]=mem[head+1 mod DEPTH].
  - dec_valid_o[0]=(count>=1), dec_valid_o[1]=(count>=2); both are forced to 0 while flush_i=1.
  - An instruction pushed at edge N is first visible after edge N; it never bypasses from input to output.
- Pop happens when dec_ready_i && !pause_buffer_i && !flush_i.
  - pop_num is the popcount of dec_valid_o, and head advances by pop_num.
  - A popped entry is never presented again.
- Simultaneous push and pop are legal: count_next = count + push_num - pop_num.
  - full_o uses the pre-update count, so a pop does not unblock a push in the same cycle.
- Flush has the highest priority.
  - Next state is head=tail=count=0; same-cycle input and pop are discarded.
  - Storage contents need not be cleared on flush.
- pause_buffer_i only blocks pops; pushes continue until full_o asserts.
- Pointer wrap: index arithmetic is mod DEPTH.
  - The slot1 write and dec_o[1] read at index DEPTH-1 wrap to entry 0.
- Exception and branch fields pass through unmodified, bit-exact, from their fetch slot to their output slot.

Test Plan:
- Reset, then push fetch_i pc={0x1c000004,0x1c000000}, valid=2'b11 (slot0 = 0x1c000000) with dec_ready_i=0.
  - Next cycle: dec_valid_o=2'b11, dec_o[0].pc=0x1c000000, dec_o[1].pc=0x1c000004, count=2.
- Push valid=2'b10 with pc[1]=0x1c000010 into an empty buffer -> dec_valid_o=2'b01, dec_o[0].pc=0x1c000010.
- Fill with dec_ready_i=0, 8 dual pushes at DEPTH=16.
  - full_o=1 once count=15/16; the next push is ignored and count stays 16.
  - dec_ready_i=1 then pops 2 per cycle in pc order with no loss or duplication.
- Run 40 cycles of continuous dual push and dual pop with head starting at 15.
  - Wrap is correct: dec_o[1] reads entry 0 when head=15, pcs strictly sequential, count constant.
- Hold count=6 and assert flush_i together with a valid push and dec_ready_i=1.
  - Same cycle: dec_valid_o=2'b00; next cycle count=0 and the pushed pair is absent.
- Hold pause_buffer_i=1 with dec_ready_i=1 for 3 cycles while pushing 2/cycle -> no pops, count grows 2→4→6→8.
- Push slot0 with is_exception=6'b000100 and exception_cause[2]=7'h08, and slot1 with pre_is_branch=1, pre_branch_addr=0x1c000100.
  - The outputs carry these fields unchanged.
- Assert rst_n=0 mid-stream at count=5 -> dec_valid_o=0 and full_o=0 immediately, without waiting for a clock edge.
